adpll_ctrl_gen2: RTL and testbench
==================================

Name: adpll_ctrl_gen2

Overview:
- Parametrised second-generation ADPLL loop controller. Sits between the PFD and the DCO; drives the DCO control word.
- Two phases of operation:
  - Binary-search frequency acquisition.
  - Linear ±1 phase tracking, with lock detection, lock-loss detection and automatic re-acquisition.
- Adds over the first generation: configurable code width, lock/unlock hysteresis, a hold mode, code saturation and a state debug output.

Parameters:
- CODE_W, 5: DCO code width in bits; must be ≥3.
- LOCK_CNT, 4: consecutive polarity flips in TRACK required to assert freq_lock; ≥2.
- UNLOCK_CNT, 4: consecutive same-direction decisions in TRACK that trigger re-acquisition; ≥2.
- REACQ_STEP_LOG2, 2: log2 of the initial search step on re-acquisition; must be < CODE_W-1.

Ports:
- phase_clk, input, 1: controller clock (one edge per PFD comparison).
- reset, input, 1: synchronous, active-high.
- p_up, input, 1: PFD decision flag valid at the phase_clk edge; 1 = DCO slow, raise code.
- p_down, input, 1: PFD decision flag; 1 = DCO fast, lower code.
- hold, input, 1: freeze code, state and counters.
- dco_code, output, CODE_W: DCO control word.
- freq_lock, output, 1: loop locked.
- polarity, output, 1: direction of the last valid decision; 1 = up.
- state, output, 2: debug; SEARCH=0, TRACK=1.

Behaviour:
- Clocking and reset:
  - One clock: phase_clk. Reset is synchronous and active-high, named reset.
  - All outputs are registered. An effect is visible one phase_clk edge after the decision is sampled.
- Reset values, also applied on reset mid-operation in any state:
  - dco_code = 2^(CODE_W-1) (16 for CODE_W=5).
  - step = 2^(CODE_W-2).
  - freq_lock = 0, polarity = 0, state = SEARCH.
  - Counters cleared.
- Decisions:
  - Valid decision: exactly one of p_up / p_down is high.
  - Both high or both low = no decision. Nothing changes, no step is consumed, counters are held.
  - hold=1: same as no decision. reset overrides hold.
- SEARCH state:
  - On up: code = min(code+step, 2^CODE_W-1).
  - On down: code = max(code-step, 0).
  - Then polarity = direction, and step halves.
  - When a decision is applied with step=1: transition to TRACK on the same edge, clear flip_cnt and run_cnt.
  - From reset, acquisition takes CODE_W-1 valid decisions.
- TRACK state:
  - On up: code+1, saturating at max.
  - On down: code-1, saturating at 0.
  - Flip (direction ≠ polarity): flip_cnt+1, saturating at LOCK_CNT; run_cnt = 1.
  - Same direction as polarity: run_cnt+1; flip_cnt = 0.
  - freq_lock sets on the edge where flip_cnt reaches LOCK_CNT. It stays set until re-acquisition or reset.
  - When run_cnt reaches UNLOCK_CNT, whether locked or not:
    - the code update is still applied;
    - freq_lock = 0, state = SEARCH, step = 2^REACQ_STEP_LOG2, counters cleared.
  - The first decision after entering TRACK is compared against the polarity left by the last search step.
- Saturation does not block counting: a decision clamped at max/min still updates polarity and the counters.

Decomposition:
- Shared package adpll_pkg:
  - state enum (SEARCH, TRACK);
  - CODE_MID / step-init helper functions;
  - direction constants (DIR_UP=1, DIR_DN=0).
- One natural sub-module: adpll_lock_det. It holds flip_cnt / run_cnt and outputs lock_set and reacq_req. The controller instantiates it.
- The code/step datapath stays in the top level.

Test Plan:
- Reset with p_up=p_down=1 held → dco_code=16, freq_lock=0, state=0. Twenty no-decision edges → no change.
- Acquisition: decisions U,U,D,D → codes 24,28,26,25; state=TRACK after the 4th edge; polarity=0.
- Lock: from the previous scenario, decisions U,D,U,D → codes 26,25,26,25; freq_lock rises on the 4th edge.
- Unlock/re-acquire: from lock, decisions U×4 → codes 26,27,28,29. On the 4th edge freq_lock=0, state=SEARCH. Next U → code 33 clamps to 31; following D → 29 (step 2).
- Saturation: from reset, U×4 → 24,28,30,31, state=TRACK. U×4 → code stays 31; re-acquire on the 4th edge.
- hold=1 with alternating decisions → all outputs frozen. Reset asserted mid-TRACK while locked → dco_code=16, freq_lock=0, state=SEARCH on the next edge.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared types, direction encoding and code/step initialisation helpers
// for the second-generation ADPLL loop controller.
package adpll_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Mid-scale DCO code used as the acquisition starting point.
    function automatic int code_mid(input int code_w);
        return 1 << (code_w - 1);
    endfunction

    // First binary-search step: a quarter of the code range.
    function automatic int step_init(input int code_w);
        return 1 << (code_w - 2);
    endfunction

endpackage

// File: rtl/adpll_lock_det.sv
// Lock / lock-loss detector for the TRACK phase. Counts consecutive
// polarity flips (lock evidence) and consecutive same-direction runs
// (lock-loss evidence). The request outputs are combinational so the
// controller can act on the same edge that the counters advance.
module adpll_lock_det
    import adpll_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic dec_en,
    input  logic dir,
    input  logic polarity,
    output logic lock_set,
    output logic reacq_req
);

    localparam int FW = $clog2(LOCK_CNT + 1);
    localparam int RW = $clog2(UNLOCK_CNT + 1);

    logic [FW-1:0] flip_cnt_r;
    logic [FW-1:0] flip_cnt_nxt_s;
    logic [RW-1:0] run_cnt_r;
    logic [RW-1:0] run_cnt_nxt_s;
    logic          flip_s;

    // Next counter values and lock / re-acquire requests for a valid TRACK decision.
    always_comb begin
        flip_cnt_nxt_s = flip_cnt_r;
        run_cnt_nxt_s  = run_cnt_r;
        lock_set       = 1'b0;
        reacq_req      = 1'b0;
        flip_s         = (dir != polarity);
        if (dec_en) begin
            if (flip_s) begin
                if (flip_cnt_r < FW'(LOCK_CNT)) begin
                    flip_cnt_nxt_s = flip_cnt_r + FW'(1);
                end else begin
                    flip_cnt_nxt_s = flip_cnt_r;
                end
                run_cnt_nxt_s = RW'(1);
                lock_set      = (flip_cnt_nxt_s == FW'(LOCK_CNT));
            end else begin
                flip_cnt_nxt_s = {FW{1'b0}};
                run_cnt_nxt_s  = run_cnt_r + RW'(1);
                reacq_req      = (run_cnt_nxt_s == RW'(UNLOCK_CNT));
            end
        end else begin
            flip_cnt_nxt_s = flip_cnt_r;
            run_cnt_nxt_s  = run_cnt_r;
        end
    end

    // Counter registers; cleared outside TRACK and when a re-acquisition fires.
    always_ff @(posedge clk) begin
        if (reset || clear || reacq_req) begin
            flip_cnt_r <= {FW{1'b0}};
            run_cnt_r  <= {RW{1'b0}};
        end else begin
            flip_cnt_r <= flip_cnt_nxt_s;
            run_cnt_r  <= run_cnt_nxt_s;
        end
    end

endmodule

// File: rtl/adpll_ctrl_gen2.sv
// Second-generation ADPLL loop controller: binary-search acquisition of the
// DCO code followed by +/-1 phase tracking with lock detection, lock-loss
// re-acquisition, hold and code saturation.
module adpll_ctrl_gen2
    import adpll_pkg::*;
#(
    parameter int CODE_W          = 5,
    parameter int LOCK_CNT        = 4,
    parameter int UNLOCK_CNT      = 4,
    parameter int REACQ_STEP_LOG2 = 2
) (
    input  logic              phase_clk,
    input  logic              reset,
    input  logic              p_up,
    input  logic              p_down,
    input  logic              hold,
    output logic [CODE_W-1:0] dco_code,
    output logic              freq_lock,
    output logic              polarity,
    output logic [1:0]        state
);

    localparam logic [CODE_W-1:0] CODE_MID_C   = CODE_W'(code_mid(CODE_W));
    localparam logic [CODE_W-1:0] STEP_INIT_C  = CODE_W'(step_init(CODE_W));
    localparam logic [CODE_W-1:0] STEP_REACQ_C = CODE_W'(1 << REACQ_STEP_LOG2);
    localparam logic [CODE_W-1:0] CODE_MAX_C   = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] ONE_C        = CODE_W'(1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CODE_W-1:0] code_r;
    logic [CODE_W-1:0] code_nxt_s;
    logic [CODE_W-1:0] step_r;
    logic [CODE_W-1:0] step_nxt_s;
    logic [CODE_W-1:0] delta_s;
    logic [CODE_W:0]   sum_s;
    logic              lock_r;
    logic              lock_nxt_s;
    logic              pol_r;
    logic              pol_nxt_s;
    logic              valid_s;
    logic              dir_s;
    logic              track_en_s;
    logic              clear_s;
    logic              lock_set_s;
    logic              reacq_s;

    // A decision counts only when exactly one flag is high and hold is low.
    assign valid_s    = (p_up ^ p_down) & ~hold;
    assign dir_s      = p_up ? DIR_UP : DIR_DN;
    assign track_en_s = valid_s & (state_r == TRACK);
    assign clear_s    = (state_r != TRACK);

    adpll_lock_det #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock_det (
        .clk       (phase_clk),
        .reset     (reset),
        .clear     (clear_s),
        .dec_en    (track_en_s),
        .dir       (dir_s),
        .polarity  (pol_r),
        .lock_set  (lock_set_s),
        .reacq_req (reacq_s)
    );

    // State register.
    always_ff @(posedge phase_clk) begin
        if (reset) begin
            state_r <= SEARCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: enter TRACK on the last search step, fall back on lock loss.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SEARCH: begin
                if (valid_s && (step_r == ONE_C)) begin
                    state_nxt_s = TRACK;
                end else begin
                    state_nxt_s = SEARCH;
                end
            end
            TRACK: begin
                if (reacq_s) begin
                    state_nxt_s = SEARCH;
                end else begin
                    state_nxt_s = TRACK;
                end
            end
            default: state_nxt_s = SEARCH;
        endcase
    end

    // Code / step / lock / polarity next values with saturating arithmetic.
    always_comb begin
        code_nxt_s = code_r;
        step_nxt_s = step_r;
        lock_nxt_s = lock_r;
        pol_nxt_s  = pol_r;
        if (state_r == TRACK) begin
            delta_s = ONE_C;
        end else begin
            delta_s = step_r;
        end
        sum_s = {1'b0, code_r} + {1'b0, delta_s};
        if (valid_s) begin
            pol_nxt_s = dir_s;
            if (dir_s == DIR_UP) begin
                if (sum_s[CODE_W]) begin
                    code_nxt_s = CODE_MAX_C;
                end else begin
                    code_nxt_s = sum_s[CODE_W-1:0];
                end
            end else begin
                if (code_r < delta_s) begin
                    code_nxt_s = {CODE_W{1'b0}};
                end else begin
                    code_nxt_s = code_r - delta_s;
                end
            end
            case (state_r)
                SEARCH: begin
                    step_nxt_s = {1'b0, step_r[CODE_W-1:1]};
                    lock_nxt_s = lock_r;
                end
                TRACK: begin
                    if (reacq_s) begin
                        step_nxt_s = STEP_REACQ_C;
                        lock_nxt_s = 1'b0;
                    end else if (lock_set_s) begin
                        lock_nxt_s = 1'b1;
                    end else begin
                        lock_nxt_s = lock_r;
                    end
                end
                default: begin
                    step_nxt_s = STEP_INIT_C;
                    lock_nxt_s = 1'b0;
                end
            endcase
        end else begin
            code_nxt_s = code_r;
            step_nxt_s = step_r;
            lock_nxt_s = lock_r;
            pol_nxt_s  = pol_r;
        end
    end

    // Datapath registers driving the outputs.
    always_ff @(posedge phase_clk) begin
        if (reset) begin
            code_r <= CODE_MID_C;
            step_r <= STEP_INIT_C;
            lock_r <= 1'b0;
            pol_r  <= 1'b0;
        end else begin
            code_r <= code_nxt_s;
            step_r <= step_nxt_s;
            lock_r <= lock_nxt_s;
            pol_r  <= pol_nxt_s;
        end
    end

    assign dco_code  = code_r;
    assign freq_lock = lock_r;
    assign polarity  = pol_r;
    assign state     = state_r;

endmodule

// File: tb/tb_adpll_ctrl_gen2.sv
// Scoreboard bench for adpll_ctrl_gen2 (CODE_W=5, LOCK_CNT=4, UNLOCK_CNT=4,
// REACQ_STEP_LOG2=2). The driver pushes hand-computed expectations for each
// edge; the monitor pops and compares after every rising edge.
module tb_adpll_ctrl_gen2;

    typedef struct {
        logic [4:0] code;
        logic       lock;
        logic       pol;
        logic [1:0] st;
        int         id;
    } exp_t;

    localparam logic [1:0] S = 2'd0;
    localparam logic [1:0] T = 2'd1;

    logic       clk;
    logic       reset;
    logic       p_up;
    logic       p_down;
    logic       hold;
    logic [4:0] dco_code;
    logic       freq_lock;
    logic       polarity;
    logic [1:0] state;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    adpll_ctrl_gen2 dut (
        .phase_clk (clk),
        .reset     (reset),
        .p_up      (p_up),
        .p_down    (p_down),
        .hold      (hold),
        .dco_code  (dco_code),
        .freq_lock (freq_lock),
        .polarity  (polarity),
        .state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one edge worth of inputs and record what must appear after it.
    task automatic drive(input logic up, input logic dn, input logic hd, input logic rst,
                         input logic [4:0] c, input logic l, input logic pl, input logic [1:0] s);
        exp_t e;
        @(negedge clk);
        p_up   = up;
        p_down = dn;
        hold   = hd;
        reset  = rst;
        e.code = c;
        e.lock = l;
        e.pol  = pl;
        e.st   = s;
        e.id   = vec_id;
        vec_id++;
        sb_q.push_back(e);
    endtask

    // Monitor: one expectation per rising edge, compared just after it.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (dco_code !== mon_e.code || freq_lock !== mon_e.lock ||
                polarity !== mon_e.pol || state !== mon_e.st) begin
                failures++;
                $display("FAIL vec%0d: got code=%0d lock=%0b pol=%0b state=%0d, want code=%0d lock=%0b pol=%0b state=%0d",
                         mon_e.id, dco_code, freq_lock, polarity, state,
                         mon_e.code, mon_e.lock, mon_e.pol, mon_e.st);
            end
        end
    end

    initial begin
        p_up   = 1'b1;
        p_down = 1'b1;
        hold   = 1'b0;
        reset  = 1'b1;

        // Reset with both flags high, then twenty no-decision edges.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd16, 1'b0, 1'b0, S);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd16, 1'b0, 1'b0, S);
        for (int i = 0; i < 20; i++) begin
            drive(i[0], i[0], 1'b0, 1'b0, 5'd16, 1'b0, 1'b0, S);
        end

        // Acquisition U,U,D,D.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd24, 1'b0, 1'b1, S);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd28, 1'b0, 1'b1, S);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd26, 1'b0, 1'b0, S);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd25, 1'b0, 1'b0, T);

        // Lock with U,D,U,D.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd26, 1'b0, 1'b1, T);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd25, 1'b0, 1'b0, T);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd26, 1'b0, 1'b1, T);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd25, 1'b1, 1'b0, T);

        // Lock loss after four ups, then re-acquire with step 4 (clamped) and 2.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd26, 1'b1, 1'b1, T);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd27, 1'b1, 1'b1, T);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd28, 1'b1, 1'b1, T);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd29, 1'b0, 1'b1, S);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, S);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd29, 1'b0, 1'b0, S);

        // Last search step back into TRACK, then relock.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd28, 1'b0, 1'b0, T);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd29, 1'b0, 1'b1, T);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd28, 1'b0, 1'b0, T);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd29, 1'b0, 1'b1, T);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd28, 1'b1, 1'b0, T);

        // Hold with alternating decisions, plus no-decision patterns: frozen.
        for (int i = 0; i < 6; i++) begin
            drive(i[0], ~i[0], 1'b1, 1'b0, 5'd28, 1'b1, 1'b0, T);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd28, 1'b1, 1'b0, T);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd28, 1'b1, 1'b0, T);

        // Reset mid-TRACK while locked overrides hold and a decision.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd16, 1'b0, 1'b0, S);

        // Upper saturation; counters held across no-decision and hold edges.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd24, 1'b0, 1'b1, S);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd28, 1'b0, 1'b1, S);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd30, 1'b0, 1'b1, S);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, T);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, T);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, T);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, T);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd31, 1'b0, 1'b1, T);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, T);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, S);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd27, 1'b0, 1'b0, S);

        // Lower saturation and re-acquisition from code 0.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd16, 1'b0, 1'b0, S);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd8,  1'b0, 1'b0, S);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, S);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd2,  1'b0, 1'b0, S);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd1,  1'b0, 1'b0, T);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, T);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, T);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, T);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, S);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, S);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd2,  1'b0, 1'b1, S);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd3,  1'b0, 1'b1, T);

        // Drain the scoreboard within a bounded number of edges.
        @(negedge clk);
        p_up   = 1'b0;
        p_down = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        checks++;
        if (sb_q.size() != 0 || checks != vec_id + 1) begin
            failures++;
            $display("FAIL drain: pending=%0d checked=%0d, want pending=0 checked=%0d",
                     sb_q.size(), checks - 1, vec_id);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
